gpio_keypad_scanner: RTL
========================

Name: gpio_keypad_scanner

Overview:
- Input-side companion to the GPIO board display driver: reads a 4x4 matrix keypad wired to the DE0 GPIO header.
- Drives one keypad row low at a time and samples the four column inputs (active-low, pulled up).
- Debounces, encodes the pressed key to a 4-bit code, and presents it on a valid/ack handshake to the processor datapath.
- One report per press; a new report requires release followed by a new press.

Parameters:
- ROW_CYCLES, 16384, clock cycles each row is driven before advancing (about 328 us at 50 MHz).
- DEBOUNCE_SAMPLES, 16, consecutive identical row-period samples required to accept a press or a release.

Ports:
- clock_50  in  1  system clock, DE0 CLOCK_50.
- reset_n  in  1  asynchronous active-low reset.
- col_in  in  4  keypad columns, active-low, asynchronous to clock_50.
- row_out  out  4  keypad row drive, active-low, one-cold.
- key_code  out  4  {row[1:0], col[1:0]} of the accepted key.
- key_valid  out  1  key_code holds an unconsumed report.
- key_ack  in  1  consumer accepts the report.
- key_down  out  1  a debounced key is currently held.
- overrun  out  1  sticky: a report was lost because key_valid was still high.

Behaviour:
- Reset (async assert, sync deassert by flop nature):
  - row_out=4'hF; key_code=0, key_valid=0, key_down=0, overrun=0.
  - state=SCAN, row index=0, period counter=0, debounce counter=0.
- Synchroniser: col_in passes through a 2-flop synchroniser before any use; this adds 2 cycles.
- Period counter:
  - Counts 0..ROW_CYCLES-1 and wraps.
  - The "sample point" is count==ROW_CYCLES-1. Columns are evaluated only there, giving the maximum settle time after a row change.
- Row drive: in every state except reset, row_out = ~(4'b0001 << row_idx).
- A sample is "single" when exactly one synchronised column is low. All-high is "none". Two or more low is "multi" and is treated as a mismatch.
- State machine (transitions occur only at sample points):
  - SCAN:
    - single: capture {row_idx, col}, clear the debounce counter, go to DEBOUNCE. row_idx is held.
    - otherwise: row_idx increments mod 4.
  - DEBOUNCE:
    - Sample equal to the captured column: increment the counter. When it reaches DEBOUNCE_SAMPLES-1, go to REPORT.
    - Any other sample (none, multi, different column): go to SCAN, row_idx+1.
  - REPORT (one cycle, not gated by the sample point):
    - If key_valid=0 or key_ack=1 this cycle: load key_code and set key_valid=1.
    - Else: keep the old key_code and set overrun=1.
    - In both cases set key_down=1, clear the counter, go to HELD.
  - HELD (row stays on the captured row):
    - none: increment the counter. When it reaches DEBOUNCE_SAMPLES-1, clear key_down and go to SCAN with row_idx+1.
    - any non-none sample: clear the counter.
- Handshake:
  - key_valid stays high until a cycle with key_valid & key_ack. It is low the following cycle.
  - key_ack while key_valid=0 is ignored.
  - Accepting a report also clears overrun.
  - If REPORT coincides with an ack, the new code wins and key_valid stays high.
- Latency: from column stable-low (first sample point) to key_valid high is DEBOUNCE_SAMPLES row periods + 1 cycle. Detection wait before that is ≤ 4 row periods.
- Presses in other rows during DEBOUNCE or HELD are invisible; this is intentional, with no rollover support.
- Reset mid-operation: immediate return to reset values; any pending report is lost.
- Counter widths are $clog2 of the respective parameter, minimum 1 bit.

Decomposition:
- Shared include gpio_board_defs.vh:
  - KP_ROWS=4, KP_COLS=4.
  - State encodings SCAN=2'd0, DEBOUNCE=2'd1, REPORT=2'd2, HELD=2'd3.
  - The column one-hot-to-index function.
- Sub-module sync2 (parameterised-width 2-flop synchroniser, async active-low reset to all-ones). It is reusable for the switch inputs on the same board.

Test Plan (ROW_CYCLES=8, DEBOUNCE_SAMPLES=3):
- Reset and idle: release reset with col_in=4'hF. row_out must step E,D,B,7,E every 8 cycles; key_valid stays 0.
- Clean press: hold col 2 low whenever row 1 is driven, for 10 periods. key_code=4'h6 and key_valid=1 exactly 3 periods + 1 cycle after the first qualifying sample; key_down=1. Ack → key_valid=0 next cycle. Release → key_down=0 after 3 none-samples, then scanning resumes.
- Bounce: toggle col 0 on row 3 every period for 6 periods, then hold low. No report during toggling. Single report key_code=4'hC after 3 stable samples.
- Overrun: press key 4'h1, do not ack, release, press key 4'hA. key_code remains 4'h1, overrun=1. Ack → key_valid=0, overrun=0.
- Multi-column: cols 0 and 1 low together on row 0. No capture, scanning continues, no key_valid.
- Reset mid-DEBOUNCE: assert reset_n=0 during the second debounce sample. All outputs immediately return to reset values; no report after deassertion until a fresh full debounce.

Source files
------------

// File: rtl/gpio_keypad_scanner_pkg.sv
// Shared definitions for the DE0 GPIO 4x4 matrix keypad scanner.
//   KP_ROWS / KP_COLS : keypad matrix geometry
//   kp_state_t        : scanner FSM states with fixed encodings
//   col_index()       : one-hot column vector to 2-bit column index
package gpio_keypad_scanner_pkg;

  localparam int unsigned KP_ROWS = 4;
  localparam int unsigned KP_COLS = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    REPORT   = 2'd2,
    HELD     = 2'd3
  } kp_state_t;

  // Callers only use this on vectors with exactly one bit set.
  function automatic logic [1:0] col_index(input logic [KP_COLS-1:0] col_low);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < KP_COLS; i++) begin
      if (col_low[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/gpio_keypad_scanner_sync2.sv
// sync2: parameterised-width two-flop synchroniser for asynchronous board
// inputs (keypad columns, slide switches).
//   clock_50 : destination clock
//   reset_n  : asynchronous active-low reset, flops reset to all-ones
//              (idle level of pulled-up inputs)
//   d        : asynchronous input
//   q        : synchronised output, two cycles behind d
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock_50,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gpio_keypad_scanner.sv
// gpio_keypad_scanner: scans a 4x4 matrix keypad on the DE0 GPIO header,
// debounces presses/releases and reports one key code per press on a
// valid/ack handshake.
//   clock_50  : system clock
//   reset_n   : asynchronous active-low reset
//   col_in    : keypad columns, active-low, asynchronous
//   row_out   : keypad row drive, active-low, one-cold (all-high in reset)
//   key_code  : {row[1:0], col[1:0]} of the accepted key
//   key_valid : key_code holds an unconsumed report
//   key_ack   : consumer accepts the report
//   key_down  : a debounced key is currently held
//   overrun   : sticky, a report was dropped while key_valid was high
module gpio_keypad_scanner
  import gpio_keypad_scanner_pkg::*;
#(
  parameter int unsigned ROW_CYCLES       = 16384,
  parameter int unsigned DEBOUNCE_SAMPLES = 16
) (
  input  logic               clock_50,
  input  logic               reset_n,
  input  logic [KP_COLS-1:0] col_in,
  output logic [KP_ROWS-1:0] row_out,
  output logic [3:0]         key_code,
  output logic               key_valid,
  input  logic               key_ack,
  output logic               key_down,
  output logic               overrun
);

  localparam int unsigned PW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam int unsigned DW = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(ROW_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_SAMPLES - 1);

  kp_state_t          state;
  logic [1:0]         row_idx;
  logic [1:0]         cap_col;
  logic [PW-1:0]      period_cnt;
  logic [DW-1:0]      db_cnt;
  logic               running;
  logic [KP_COLS-1:0] col_sync;
  logic [KP_COLS-1:0] col_low;
  logic [KP_ROWS-1:0] row_onehot;
  logic               sample_pt;
  logic               single;
  logic               none;
  logic               hit;

  sync2 #(.WIDTH(KP_COLS)) u_col_sync (
    .clock_50 (clock_50),
    .reset_n  (reset_n),
    .d        (col_in),
    .q        (col_sync)
  );

  always_comb begin
    col_low   = ~col_sync;
    sample_pt = (period_cnt == PERIOD_LAST);
    single    = $onehot(col_low);
    none      = (col_low == '0);
    hit       = single && (col_index(col_low) == cap_col);
  end

  // running keeps the rows released while reset is asserted.
  always_comb begin
    row_onehot          = '0;
    row_onehot[row_idx] = 1'b1;
    row_out             = running ? ~row_onehot : '1;
  end

  // Debounce and release both fire on the sample that finds db_cnt already
  // at DEBOUNCE_SAMPLES-1, i.e. DEBOUNCE_SAMPLES qualifying samples after
  // the capturing/first sample.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SCAN;
      row_idx    <= '0;
      cap_col    <= '0;
      period_cnt <= '0;
      db_cnt     <= '0;
      running    <= 1'b0;
      key_code   <= '0;
      key_valid  <= 1'b0;
      key_down   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      running    <= 1'b1;
      period_cnt <= sample_pt ? '0 : period_cnt + 1'b1;

      if (key_valid && key_ack) begin
        key_valid <= 1'b0;
        overrun   <= 1'b0;
      end

      unique case (state)
        SCAN: begin
          if (sample_pt) begin
            if (single) begin
              cap_col <= col_index(col_low);
              db_cnt  <= '0;
              state   <= DEBOUNCE;
            end else begin
              row_idx <= row_idx + 2'd1;
            end
          end
        end
        DEBOUNCE: begin
          if (sample_pt) begin
            if (hit) begin
              if (db_cnt == DB_LAST) state  <= REPORT;
              else                   db_cnt <= db_cnt + 1'b1;
            end else begin
              state   <= SCAN;
              row_idx <= row_idx + 2'd1;
            end
          end
        end
        REPORT: begin
          // Overrides the ack clear above so a coincident ack keeps the new code.
          if (!key_valid || key_ack) begin
            key_code  <= {row_idx, cap_col};
            key_valid <= 1'b1;
          end else begin
            overrun   <= 1'b1;
          end
          key_down <= 1'b1;
          db_cnt   <= '0;
          state    <= HELD;
        end
        HELD: begin
          if (sample_pt) begin
            if (none) begin
              if (db_cnt == DB_LAST) begin
                key_down <= 1'b0;
                db_cnt   <= '0;
                row_idx  <= row_idx + 2'd1;
                state    <= SCAN;
              end else begin
                db_cnt <= db_cnt + 1'b1;
              end
            end else begin
              db_cnt <= '0;
            end
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule
